// File: rtl/bec_slave_if_if.sv
// Master/slave bus bundle between the BEC master controller and the slave
// endpoint: operand write phase, processing request, key handshake, results.
interface bec_slave_if_if;
    logic         master_ena_proc;
    logic         load_data;
    logic [2:0]   load_status;
    logic         trigLoad;
    logic [162:0] m_data;
    logic         ki;
    logic         next_key;
    logic [3:0]   becStatus;
    logic         slv_done;
    logic [162:0] s_data;

    modport master (
        output master_ena_proc, load_data, load_status, trigLoad, m_data, ki,
        input  next_key, becStatus, slv_done, s_data
    );

    modport slave (
        input  master_ena_proc, load_data, load_status, trigLoad, m_data, ki,
        output next_key, becStatus, slv_done, s_data
    );
endinterface

// File: rtl/bec_slave_if.sv
// Slave endpoint of the BEC bus: captures six 163-bit operands from the
// master, sequences the datapath core once per key bit with a key-advance
// handshake back to the master, and returns the result coordinates.
module bec_slave_if #(
    parameter int KEY_BITS = 163
) (
    input  logic            clk,
    input  logic            rst,
    bec_slave_if_if.slave   bus,
    output logic            core_step,
    output logic            core_ki,
    input  logic            core_done,
    input  logic [162:0]    core_res_w,
    input  logic [162:0]    core_res_z,
    output logic [162:0]    op_w1,
    output logic [162:0]    op_z1,
    output logic [162:0]    op_w2,
    output logic [162:0]    op_z2,
    output logic [162:0]    op_inv_w0,
    output logic [162:0]    op_d
);

    localparam int CNT_W = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STEP = 3'd1,
        WAIT = 3'd2,
        ADV  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [5:0]         loaded;
    logic               err;
    logic               trig_q;
    logic               ena_q;
    logic               ld_q;
    logic [162:0]       s_data_r;
    logic [162:0]       bank_w1, bank_z1, bank_w2, bank_z2, bank_inv_w0, bank_d;

    logic               trig_rise;
    logic               ena_rise;
    logic               ld_rise;
    logic               capture_ok;

    assign trig_rise  = bus.trigLoad & ~trig_q;
    assign ena_rise   = bus.master_ena_proc & ~ena_q;
    assign ld_rise    = bus.load_data & ~ld_q;
    // The operand bank is frozen while the core is iterating over it.
    assign capture_ok = (state == IDLE) || (state == DONE);

    // Edge detectors, operand capture, error flag and the run-sequencing FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            loaded      <= '0;
            err         <= 1'b0;
            trig_q      <= 1'b0;
            ena_q       <= 1'b0;
            ld_q        <= 1'b0;
            s_data_r    <= '0;
            bank_w1     <= '0;
            bank_z1     <= '0;
            bank_w2     <= '0;
            bank_z2     <= '0;
            bank_inv_w0 <= '0;
            bank_d      <= '0;
        end else begin
            trig_q <= bus.trigLoad;
            ena_q  <= bus.master_ena_proc;
            ld_q   <= bus.load_data;

            if (capture_ok && trig_rise && bus.load_data) begin
                case (bus.load_status)
                    3'd0: begin bank_w1     <= bus.m_data; loaded[0] <= 1'b1; err <= 1'b0; end
                    3'd1: begin bank_z1     <= bus.m_data; loaded[1] <= 1'b1; err <= 1'b0; end
                    3'd2: begin bank_w2     <= bus.m_data; loaded[2] <= 1'b1; err <= 1'b0; end
                    3'd3: begin bank_z2     <= bus.m_data; loaded[3] <= 1'b1; err <= 1'b0; end
                    3'd4: begin bank_inv_w0 <= bus.m_data; loaded[4] <= 1'b1; err <= 1'b0; end
                    3'd5: begin bank_d      <= bus.m_data; loaded[5] <= 1'b1; err <= 1'b0; end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (ena_rise) begin
                        if (loaded == 6'h3F) begin
                            state <= STEP;
                            cnt   <= CNT_W'(KEY_BITS - 1);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                STEP: begin
                    if (!bus.master_ena_proc) state <= IDLE;
                    else                      state <= WAIT;
                end
                WAIT: begin
                    if (!bus.master_ena_proc) state <= IDLE;
                    else if (core_done)       state <= ADV;
                end
                ADV: begin
                    if (!bus.master_ena_proc) begin
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt - CNT_W'(1);
                        state <= STEP;
                    end
                end
                DONE: begin
                    s_data_r <= bus.load_status[0] ? core_res_z : core_res_w;
                    if (ld_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status code: error overrides, otherwise phase and operand fill level.
    always_comb begin
        bus.becStatus = 4'h0;
        if (err) begin
            bus.becStatus = 4'hF;
        end else begin
            case (state)
                IDLE: begin
                    if (loaded == 6'h3F)     bus.becStatus = 4'h2;
                    else if (loaded != 6'h0) bus.becStatus = 4'h1;
                    else                     bus.becStatus = 4'h0;
                end
                STEP, WAIT, ADV: bus.becStatus = 4'h4;
                DONE:            bus.becStatus = 4'h8;
                default:         bus.becStatus = 4'h0;
            endcase
        end
    end

    // Key advance is suppressed when the master aborts during ADV.
    assign core_step    = (state == STEP);
    assign core_ki      = (state == STEP) & bus.ki;
    assign bus.next_key = (state == ADV) & bus.master_ena_proc;
    assign bus.slv_done = (state == DONE);
    assign bus.s_data   = s_data_r;

    assign op_w1     = bank_w1;
    assign op_z1     = bank_z1;
    assign op_w2     = bank_w2;
    assign op_z2     = bank_z2;
    assign op_inv_w0 = bank_inv_w0;
    assign op_d      = bank_d;

endmodule

// File: tb/tb_bec_slave_if.sv
// Directed bench for bec_slave_if with a four-bit key: operand loading,
// incomplete-mask error, full run, slow core with abort, result readback,
// reserved load code and asynchronous reset.
module tb_bec_slave_if;

    localparam logic [162:0] P_W1  = 163'h1_2345_6789_ABCD_EF01_2345;
    localparam logic [162:0] P_Z1  = 163'h2A5_A5A5_A5A5_A5A5;
    localparam logic [162:0] P_W2  = 163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0001;
    localparam logic [162:0] P_Z2  = 163'hDEAD_BEEF;
    localparam logic [162:0] P_INV = 163'h3_C3C3_C3C3;
    localparam logic [162:0] P_D   = 163'h5A5A_0F0F_1234;
    localparam logic [162:0] P_BAD = 163'h7777_7777;

    logic         clk;
    logic         rst;
    logic         core_step;
    logic         core_ki;
    logic         core_done;
    logic [162:0] core_res_w;
    logic [162:0] core_res_z;
    logic [162:0] op_w1, op_z1, op_w2, op_z2, op_inv_w0, op_d;

    int           vectors;
    int           miscompares;
    int           steps;
    int           nks;
    int           done_at;
    logic [3:0]   key;
    logic [3:0]   ki_seq;
    logic [3:0]   run_status;

    bec_slave_if_if bus ();

    bec_slave_if #(.KEY_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .core_step  (core_step),
        .core_ki    (core_ki),
        .core_done  (core_done),
        .core_res_w (core_res_w),
        .core_res_z (core_res_z),
        .op_w1      (op_w1),
        .op_z1      (op_z1),
        .op_w2      (op_w2),
        .op_z2      (op_z2),
        .op_inv_w0  (op_inv_w0),
        .op_d       (op_d)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [162:0] observed,
                               input logic [162:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One master write: trigLoad rising edge with load_data high.
    task automatic applyStimulus(input logic [2:0] code, input logic [162:0] data);
        bus.load_data   = 1'b1;
        bus.load_status = code;
        bus.m_data      = data;
        bus.trigLoad    = 1'b1;
        tick();
        bus.trigLoad    = 1'b0;
        tick();
        bus.load_data   = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst                 = 1'b1;
        bus.master_ena_proc = 1'b0;
        bus.load_data       = 1'b0;
        bus.load_status     = 3'd0;
        bus.trigLoad        = 1'b0;
        bus.m_data          = '0;
        bus.ki              = 1'b0;
        core_done           = 1'b0;
        core_res_w          = 163'h5;
        core_res_z          = 163'hA;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        $display("[TB] reset state");
        checkOutput("rst_status",   163'(bus.becStatus), 163'h0);
        checkOutput("rst_slv_done", 163'(bus.slv_done),  163'h0);
        checkOutput("rst_s_data",   bus.s_data,          163'h0);
        checkOutput("rst_next_key", 163'(bus.next_key),  163'h0);
        checkOutput("rst_core_step",163'(core_step),     163'h0);
        checkOutput("rst_op_w1",    op_w1,               163'h0);

        $display("[TB] load five operands");
        applyStimulus(3'd0, P_W1);
        checkOutput("op_w1",        op_w1,               P_W1);
        checkOutput("status_part",  163'(bus.becStatus), 163'h1);
        applyStimulus(3'd1, P_Z1);
        checkOutput("op_z1",        op_z1,               P_Z1);
        applyStimulus(3'd2, P_W2);
        checkOutput("op_w2",        op_w2,               P_W2);
        applyStimulus(3'd3, P_Z2);
        checkOutput("op_z2",        op_z2,               P_Z2);
        applyStimulus(3'd4, P_INV);
        checkOutput("op_inv_w0",    op_inv_w0,           P_INV);
        checkOutput("status_five",  163'(bus.becStatus), 163'h1);

        $display("[TB] start with incomplete mask");
        bus.master_ena_proc = 1'b1;
        tick();
        checkOutput("err_status",   163'(bus.becStatus), 163'hF);
        tick();
        checkOutput("err_no_step",  163'(core_step),     163'h0);
        checkOutput("err_sticky",   163'(bus.becStatus), 163'hF);
        bus.master_ena_proc = 1'b0;
        tick();

        applyStimulus(3'd5, P_D);
        checkOutput("op_d",         op_d,                P_D);
        checkOutput("status_full",  163'(bus.becStatus), 163'h2);

        $display("[TB] full run, key 1011, core_done tied high");
        key        = 4'b1011;
        bus.ki     = key[0];
        core_done  = 1'b1;
        steps      = 0;
        nks        = 0;
        done_at    = 0;
        ki_seq     = 4'b0000;
        run_status = 4'h0;
        bus.master_ena_proc = 1'b1;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            tick();
            if (k == 1) run_status = bus.becStatus;
            if (core_step) begin
                ki_seq = {core_ki, ki_seq[3:1]};
                steps++;
            end
            if (bus.next_key) begin
                nks++;
                key    = key >> 1;
                bus.ki = key[0];
            end
            if (bus.slv_done) done_at = k;
        end
        checkOutput("run_status",   163'(run_status),    163'h4);
        checkOutput("run_ki_seq",   163'(ki_seq),        163'hB);
        checkOutput("run_steps",    163'(steps),         163'd4);
        checkOutput("run_next_key", 163'(nks),           163'd4);
        checkOutput("run_done_cyc", 163'(done_at),       163'd13);
        checkOutput("done_status",  163'(bus.becStatus), 163'h8);

        $display("[TB] result readback");
        bus.load_status = 3'd0;
        tick();
        checkOutput("s_data_w",     bus.s_data,          163'h5);
        bus.load_status = 3'd1;
        tick();
        checkOutput("s_data_z",     bus.s_data,          163'hA);
        checkOutput("done_held",    163'(bus.slv_done),  163'h1);
        bus.master_ena_proc = 1'b0;
        bus.load_data       = 1'b1;
        tick();
        checkOutput("done_exit",    163'(bus.slv_done),  163'h0);
        checkOutput("exit_status",  163'(bus.becStatus), 163'h2);
        bus.load_data = 1'b0;
        tick();

        $display("[TB] slow core and abort");
        key       = 4'b0110;
        bus.ki    = key[0];
        core_done = 1'b0;
        bus.master_ena_proc = 1'b1;
        tick();
        checkOutput("slow_step",    163'(core_step),     163'h1);
        nks = 0;
        repeat (5) begin
            tick();
            if (bus.next_key) nks++;
        end
        checkOutput("wait_status",  163'(bus.becStatus), 163'h4);
        checkOutput("wait_no_nk",   163'(nks),           163'd0);
        core_done = 1'b1;
        tick();
        checkOutput("adv_nk",       163'(bus.next_key),  163'h1);
        tick();
        checkOutput("step2",        163'(core_step),     163'h1);
        core_done = 1'b0;
        tick();
        tick();
        checkOutput("step_done_ign",163'(core_step),     163'h0);
        checkOutput("wait2_no_nk",  163'(bus.next_key),  163'h0);
        bus.master_ena_proc = 1'b0;
        tick();
        checkOutput("abort_status", 163'(bus.becStatus), 163'h2);
        checkOutput("abort_no_done",163'(bus.slv_done),  163'h0);
        repeat (3) tick();
        checkOutput("abort_idle_nk",163'(bus.next_key),  163'h0);
        checkOutput("abort_op_z2",  op_z2,               P_Z2);

        $display("[TB] reserved code and reset during WAIT");
        applyStimulus(3'd7, P_BAD);
        checkOutput("code7_w1",     op_w1,               P_W1);
        checkOutput("code7_d",      op_d,                P_D);
        checkOutput("code7_status", 163'(bus.becStatus), 163'h2);
        bus.master_ena_proc = 1'b1;
        tick();
        tick();
        checkOutput("pre_rst_wait", 163'(bus.becStatus), 163'h4);
        rst = 1'b1;
        #1;
        checkOutput("arst_status",  163'(bus.becStatus), 163'h0);
        checkOutput("arst_step",    163'(core_step),     163'h0);
        checkOutput("arst_s_data",  bus.s_data,          163'h0);
        checkOutput("arst_op_w1",   op_w1,               163'h0);
        checkOutput("arst_op_d",    op_d,                163'h0);
        checkOutput("arst_done",    163'(bus.slv_done),  163'h0);
        bus.master_ena_proc = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("post_rst_stat",163'(bus.becStatus), 163'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bec_slave_if.md
# bec_slave_if

Slave-side endpoint of the BEC interconnection bus: the responder that sits opposite the LA-driven master controller. It captures the six 163-bit operands (w1, z1, w2, z2, inv_w0, d) pushed by the master into an operand bank and presents them to the BEC datapath core. It then steps the core once per key bit, handshaking key advance with the master via `next_key`, and returns results with `slv_done`.

## Interface
- KEY_BITS, 163, number of key-bit iterations per run (2..256)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- master_ena_proc  in  1  master requests processing; held high until `slv_done`
- load_data  in  1  master in write phase
- load_status  in  3  operand select: 0 w1, 1 z1, 2 w2, 3 z2, 4 inv_w0, 5 d; 6/7 reserved
- trigLoad  in  1  master word-ready strobe; capture on rising edge
- m_data  in  163  operand word from master
- ki  in  1  current key bit from master
- next_key  out  1  one-cycle pulse: master shifts key right by one
- becStatus  out  4  slave status code
- slv_done  out  1  run complete, results valid
- s_data  out  163  result word to master
- core_step  out  1  one-cycle pulse: core performs one ladder step
- core_ki  out  1  key bit for the current step
- core_done  in  1  core step finished (level or pulse)
- core_res_w, core_res_z  in  163 each  core result coordinates
- op_w1, op_z1, op_w2, op_z2, op_inv_w0, op_d  out  163 each  operand bank to core

## Operation
- States: IDLE, STEP, WAIT, ADV, DONE.
- Capture (any state except STEP/WAIT/ADV): `trigLoad` 0->1 with `load_data`=1 writes `m_data` to the bank entry chosen by `load_status`, sets that entry's bit in 6-bit `loaded` mask. Codes 6/7: no write, no mask change. Captures during STEP/WAIT/ADV ignored.
- IDLE: `master_ena_proc` 0->1 with `loaded`==6'h3F -> STEP, cnt <= KEY_BITS-1. With incomplete mask: stay IDLE, set sticky `err`; `err` cleared by next valid capture.
- STEP: `core_step`=1, `core_ki`=`ki`; -> WAIT.
- WAIT: `core_done`=1 -> ADV. `core_done` in STEP cycle is ignored.
- ADV: `next_key`=1; cnt==0 -> DONE, else cnt-1 -> STEP.
- DONE: `slv_done`=1; `s_data` registered: `core_res_w` when `load_status[0]`=0, `core_res_z` when 1. Leaves to IDLE on `load_data` 0->1 (new transaction); that rising edge's trigLoad capture is still honoured.
- Abort: `master_ena_proc`=0 in STEP/WAIT/ADV -> IDLE next cycle, no `slv_done`, no `next_key`; operands and mask kept.
- `becStatus`: IDLE 4'h0 (mask empty) / 4'h1 (partial) / 4'h2 (full); STEP/WAIT/ADV 4'h4; DONE 4'h8; `err` overrides with 4'hF.
- `core_step`, `core_ki`, `next_key` are 0 outside their state.

## Timing
- Reset values: state IDLE, bank and mask 0, `err` 0, `slv_done` 0, `s_data` 0, `next_key` 0, `core_step` 0, `core_ki` 0, `becStatus` 4'h0; `op_*` 0.
- Capture: bank updated at clock edge after the cycle where `trigLoad` rise is detected (edge detector register, 1-cycle latency); `op_*` visible same edge.
- Start: `master_ena_proc` rise sampled at edge N -> STEP in cycle N+1.
- Per bit minimum 3 cycles (STEP, WAIT with `core_done`=1, ADV); total run >= 3*KEY_BITS cycles.
- `slv_done` high the first cycle in DONE; `s_data` valid from the following cycle and tracks `load_status` with 1-cycle latency.
- `ki` must be stable in STEP; master shifts on `next_key`, so next bit is valid by next STEP.
- rst mid-run: immediate return to reset values, asynchronous.

## Test plan
- Load all six operands with distinct patterns (e.g. 163'h1..., 163'h2A5...) via trigLoad edges -> `op_*` match, `becStatus` 0->1->2.
- Start with KEY_BITS=4, `core_done` tied 1, key 4'b1011 -> `core_ki` sequence 1,1,0,1, four `next_key` pulses, `slv_done` at cycle 13 after start.
- Start with only 5 operands loaded -> stays IDLE, `becStatus`=4'hF; load missing operand -> 4'h2, start proceeds.
- `core_done` delayed 5 cycles per step -> WAIT holds, no extra `next_key`; abort via `master_ena_proc`=0 mid-run -> IDLE, `slv_done` stays 0.
- DONE with core_res_w=163'h5, core_res_z=163'hA: `load_status`=0 -> `s_data`=5; =1 -> 10; `load_data` rise -> IDLE, `slv_done` 0.
- Assert rst during WAIT and with load_status=7 capture -> all outputs reset values; code 7 leaves bank unchanged.
